// File: rtl/branch_predict_ctrl_pkg.sv
// Shared definitions for the branch direction predictor.
//   - FSM state encodings (ST_IDLE, ST_RECOVER)
//   - 2-bit counter encodings (strongly/weakly not-taken, weakly/strongly taken)
//   - Default table size (log2 of the entry count)
package branch_predict_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RECOVER = 1'b1
    } bp_state_t;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    localparam int BHT_INDEX_BITS_DEFAULT = 6;

endpackage

// File: rtl/branch_predict_ctrl_sat_counter2.sv
// sat_counter2: next-value logic for one 2-bit saturating up/down counter.
// Ports:
//   cnt      in   current counter value
//   taken    in   1 = count up (saturate at 11), 0 = count down (saturate at 00)
//   cnt_next out  updated counter value
module sat_counter2
    import branch_predict_ctrl_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] cnt_next
);

    always_comb begin
        cnt_next = cnt;
        if (taken) begin
            if (cnt != CNT_ST) begin
                cnt_next = cnt + 2'd1;
            end
        end else begin
            if (cnt != CNT_SNT) begin
                cnt_next = cnt - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: branch direction predictor (table of 2-bit saturating
// counters) plus the misprediction recovery sequencer (redirect + flush).
//
// Optional feature macro: BRANCH_PREDICT_STATS_EN (adds the stat_* counters).
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   id_branch, id_pc     ID-stage conditional branch and its PC
//   id_pred_taken        combinational prediction for ID (0 when id_branch=0)
//   stall                pipeline stall; EX resolution not consumed while high
//   ex_branch, ex_pc     EX-stage conditional branch and its PC
//   ex_pred_taken        prediction carried down from ID
//   branch_taken         actual outcome from BranchLogic
//   ex_target            computed branch target
//   redirect             one-cycle pulse, fetch loads redirect_pc
//   redirect_pc          corrected PC (valid while redirect=1)
//   flush                squash younger instructions
//   busy                 high while recovering
//   stat_branches        (macro only) resolved branch count
//   stat_mispredicts     (macro only) mispredicted branch count
module branch_predict_ctrl
    import branch_predict_ctrl_pkg::*;
#(
    parameter int BHT_INDEX_BITS = BHT_INDEX_BITS_DEFAULT,
    parameter int XLEN           = 32,
    parameter int FLUSH_CYCLES   = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            id_branch,
    input  logic [XLEN-1:0] id_pc,
    output logic            id_pred_taken,
    input  logic            stall,
    input  logic            ex_branch,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_pred_taken,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] ex_target,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            busy
`ifdef BRANCH_PREDICT_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int NUM_ENTRIES = 1 << BHT_INDEX_BITS;
    localparam int CNT_W       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    logic [1:0]                bht [NUM_ENTRIES];
    logic [BHT_INDEX_BITS-1:0] id_idx;
    logic [BHT_INDEX_BITS-1:0] ex_idx;
    logic [1:0]                ex_cnt_next;
    logic                      res;
    logic                      mis;

    bp_state_t                 state_q, state_d;
    logic [CNT_W-1:0]          flush_cnt_q, flush_cnt_d;
    logic                      redirect_d, flush_d, busy_d;
    logic [XLEN-1:0]           redirect_pc_d;

    // Only the index field of the ID PC feeds the table lookup.
    logic unused_id_pc_bits;
    assign unused_id_pc_bits = ^{id_pc[XLEN-1:BHT_INDEX_BITS+2], id_pc[1:0]};

    assign id_idx = id_pc[BHT_INDEX_BITS+1:2];
    assign ex_idx = ex_pc[BHT_INDEX_BITS+1:2];

    // Lookup reads the registered table, so a same-cycle update of the
    // same entry is seen by ID only on the following cycle.
    assign id_pred_taken = id_branch & bht[id_idx][1];

    // Branches reaching EX while recovering are wrong-path and are dropped.
    assign res = ex_branch & ~stall & (state_q == ST_IDLE);
    assign mis = res & (branch_taken != ex_pred_taken);

    sat_counter2 u_sat_counter2 (
        .cnt      (bht[ex_idx]),
        .taken    (branch_taken),
        .cnt_next (ex_cnt_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                bht[i] <= CNT_WNT;
            end
        end else if (res) begin
            bht[ex_idx] <= ex_cnt_next;
        end
    end

    // Recovery sequencer: next state and registered outputs.
    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        redirect_d    = 1'b0;
        flush_d       = 1'b0;
        busy_d        = 1'b0;
        redirect_pc_d = redirect_pc;
        case (state_q)
            ST_IDLE: begin
                if (mis) begin
                    state_d       = ST_RECOVER;
                    redirect_d    = 1'b1;
                    flush_d       = 1'b1;
                    busy_d        = 1'b1;
                    flush_cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                    redirect_pc_d = branch_taken ? ex_target
                                                 : ex_pc + {{(XLEN-3){1'b0}}, 3'b100};
                end
            end
            ST_RECOVER: begin
                // Countdown runs regardless of stall.
                if (flush_cnt_q != '0) begin
                    flush_cnt_d = flush_cnt_q - CNT_W'(1);
                    flush_d     = 1'b1;
                    busy_d      = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            flush       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            redirect    <= redirect_d;
            redirect_pc <= redirect_pc_d;
            flush       <= flush_d;
            busy        <= busy_d;
        end
    end

`ifdef BRANCH_PREDICT_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (res) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mis) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
module tb_branch_predict_ctrl;

    logic        clk;
    logic        reset_n;
    logic        id_branch;
    logic [31:0] id_pc;
    logic        id_pred_taken;
    logic        stall;
    logic        ex_branch;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic        branch_taken;
    logic [31:0] ex_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        busy;
`ifdef BRANCH_PREDICT_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int total;
    int passed;
    int fails;

    branch_predict_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .id_branch     (id_branch),
        .id_pc         (id_pc),
        .id_pred_taken (id_pred_taken),
        .stall         (stall),
        .ex_branch     (ex_branch),
        .ex_pc         (ex_pc),
        .ex_pred_taken (ex_pred_taken),
        .branch_taken  (branch_taken),
        .ex_target     (ex_target),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .flush         (flush),
        .busy          (busy)
`ifdef BRANCH_PREDICT_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic tkn, input logic pred,
                           input logic [31:0] tgt);
        ex_branch     = 1'b1;
        ex_pc         = pc;
        branch_taken  = tkn;
        ex_pred_taken = pred;
        ex_target     = tgt;
        tick();
        ex_branch     = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic exp);
        id_branch = 1'b1;
        id_pc     = pc;
        #1;
        chk(tag, {31'd0, id_pred_taken}, {31'd0, exp});
    endtask

    initial begin
        total = 0; passed = 0; fails = 0;
        reset_n = 1'b0; id_branch = 1'b0; id_pc = '0; stall = 1'b0;
        ex_branch = 1'b0; ex_pc = '0; ex_pred_taken = 1'b0;
        branch_taken = 1'b0; ex_target = '0;
        #12;
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        tick();

        // 1: weakly not-taken after reset (0x100/0x200/0x300 all share entry 0)
        lookup("t1_pred_0x100", 32'h100, 1'b0);

        // 2: taken mispredict at 0x100, entry 0: 01 -> 10
        resolve(32'h100, 1'b1, 1'b0, 32'h80);
        chk("t2_redirect", {31'd0, redirect}, 32'd1);
        chk("t2_redirect_pc", redirect_pc, 32'h80);
        chk("t2_flush_c1", {31'd0, flush}, 32'd1);
        chk("t2_busy_c1", {31'd0, busy}, 32'd1);
        tick();
        chk("t2_redirect_c2", {31'd0, redirect}, 32'd0);
        chk("t2_flush_c2", {31'd0, flush}, 32'd1);
        chk("t2_busy_c2", {31'd0, busy}, 32'd1);
        tick();
        chk("t2_flush_c3", {31'd0, flush}, 32'd0);
        chk("t2_busy_c3", {31'd0, busy}, 32'd0);
        lookup("t2_pred_0x100", 32'h100, 1'b1);
        id_branch = 1'b0;
        #1;
        chk("t2_pred_gated", {31'd0, id_pred_taken}, 32'd0);

        // 3: entry 0: 10 -> 11 -> 11 -> 11, all correctly predicted
        for (int i = 0; i < 3; i++) begin
            resolve(32'h200, 1'b1, 1'b1, 32'h40);
            chk("t3_no_redirect_taken", {31'd0, redirect}, 32'd0);
        end
        // First not-taken mispredicts: 11 -> 10, still predicts taken
        resolve(32'h200, 1'b0, 1'b1, 32'h40);
        chk("t3_nt_redirect", {31'd0, redirect}, 32'd1);
        chk("t3_nt_redirect_pc", redirect_pc, 32'h204);
        tick();
        tick();
        chk("t3_busy_done", {31'd0, busy}, 32'd0);
        lookup("t3_pred_after_1nt", 32'h200, 1'b1);
        // 10 -> 01 -> 00, correctly predicted not-taken
        resolve(32'h200, 1'b0, 1'b0, 32'h40);
        resolve(32'h200, 1'b0, 1'b0, 32'h40);
        chk("t3_no_redirect_nt", {31'd0, redirect}, 32'd0);
        lookup("t3_pred_after_3nt", 32'h200, 1'b0);
        // A taken from 00 gives 01 (still 0); from 01 it would give 10
        resolve(32'h200, 1'b1, 1'b0, 32'h40);
        tick();
        tick();
        lookup("t3_sat_low", 32'h200, 1'b0);

        // 4: wrong-path branch during RECOVER; entry 1 goes 01 -> 10 first
        resolve(32'h104, 1'b1, 1'b0, 32'h400);
        ex_branch = 1'b1; ex_pc = 32'h104; branch_taken = 1'b0; ex_pred_taken = 1'b1;
        tick();
        ex_branch = 1'b0;
        chk("t4_no_second_redirect", {31'd0, redirect}, 32'd0);
        chk("t4_flush_c2", {31'd0, flush}, 32'd1);
        tick();
        chk("t4_busy_done", {31'd0, busy}, 32'd0);
        chk("t4_no_redirect_c3", {31'd0, redirect}, 32'd0);
        lookup("t4_not_trained", 32'h104, 1'b1);
        // Stalled branch in IDLE on entry 2 (01) is ignored
        stall = 1'b1;
        resolve(32'h108, 1'b1, 1'b0, 32'h500);
        stall = 1'b0;
        chk("t4_stall_redirect", {31'd0, redirect}, 32'd0);
        chk("t4_stall_busy", {31'd0, busy}, 32'd0);
        lookup("t4_stall_not_trained", 32'h108, 1'b0);

        // 5: entry 0 is 01; same-cycle lookup and taken update -> old value
        id_branch = 1'b1; id_pc = 32'h300;
        ex_branch = 1'b1; ex_pc = 32'h300; branch_taken = 1'b1; ex_pred_taken = 1'b1;
        #1;
        chk("t5_read_old", {31'd0, id_pred_taken}, 32'd0);
        tick();
        ex_branch = 1'b0;
        #1;
        chk("t5_read_new", {31'd0, id_pred_taken}, 32'd1);
        chk("t5_no_redirect", {31'd0, redirect}, 32'd0);

        // 6: not-taken mispredict at the top of the address space wraps to 0
        resolve(32'hFFFF_FFFC, 1'b0, 1'b1, 32'h1234);
        chk("t6_redirect", {31'd0, redirect}, 32'd1);
        chk("t6_redirect_pc_wrap", redirect_pc, 32'h0);
`ifdef BRANCH_PREDICT_STATS_EN
        chk("t6_stat_branches", stat_branches, 32'd11);
        chk("t6_stat_mispredicts", stat_mispredicts, 32'd5);
`endif
        reset_n = 1'b0;
        #1;
        chk("t6_rst_flush", {31'd0, flush}, 32'd0);
        chk("t6_rst_redirect", {31'd0, redirect}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        lookup("t6_rst_counters", 32'h300, 1'b0);
`ifdef BRANCH_PREDICT_STATS_EN
        chk("t6_rst_stat_mispredicts", stat_mispredicts, 32'd0);
`endif
        #2;
        reset_n = 1'b1;
        tick();
        chk("t6_idle_after_rst", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Branch direction predictor and misprediction recovery sequencer for the RV32I pipeline.
- Holds a table of 2-bit saturating counters. Gives a taken/not-taken prediction to ID for each conditional branch.
- Compares the EX-stage resolution from BranchLogic (branch_taken) with the carried prediction. On a mismatch it sequences the PC redirect and pipeline flush.
- Sits between the PC/fetch logic, the ID stage and the EX-stage BranchLogic.

Parameters:
- BHT_INDEX_BITS, 6, log2 of the counter count (64 entries); index = pc[BHT_INDEX_BITS+1:2].
- XLEN, 32, PC width.
- FLUSH_CYCLES, 2, number of cycles flush is held after a mispredict (clears IF/ID and ID/EX).

Ports:
- clk  in  1  core clock, all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- id_branch  in  1  ID holds a conditional branch (opcode BRANCH).
- id_pc  in  XLEN  PC of the ID instruction.
- id_pred_taken  out  1  combinational prediction = MSB of the counter indexed by id_pc; 0 when id_branch=0.
- stall  in  1  pipeline stall; EX resolution is not consumed while high.
- ex_branch  in  1  EX holds a valid conditional branch (same signal as BranchLogic .branch).
- ex_pc  in  XLEN  PC of the EX branch.
- ex_pred_taken  in  1  prediction carried down the pipe from ID.
- branch_taken  in  1  actual outcome from BranchLogic.
- ex_target  in  XLEN  computed branch target.
- redirect  out  1  one-cycle pulse: fetch loads redirect_pc.
- redirect_pc  out  XLEN  corrected PC; valid while redirect=1.
- flush  out  1  squash younger instructions.
- busy  out  1  high in state RECOVER.

Behaviour:
- Reset (async, reset_n=0): every counter = 2'b01 (weakly not-taken); state=IDLE; redirect=0; redirect_pc=0; flush=0; busy=0; flush counter=0. All outputs registered except id_pred_taken.

- Resolve event: `res = ex_branch & ~stall & (state==IDLE)`.
  - Branches in EX during RECOVER are wrong-path. They are ignored: no training, no redirect.
- Mispredict: `mis = res & (branch_taken != ex_pred_taken)`.

- Counter training on res, at index ex_pc[BHT_INDEX_BITS+1:2]:
  - taken: increment, saturating at 2'b11.
  - not taken: decrement, saturating at 2'b00.
- Same-cycle ID lookup and EX update of the same index: the lookup returns the pre-update value (read-old).

- FSM:
  - IDLE: on mis → RECOVER.
    - Next cycle: redirect=1, flush=1, busy=1, flush counter=FLUSH_CYCLES-1.
    - redirect_pc = branch_taken ? ex_target : ex_pc+4 (mod 2^XLEN; wrap at 0xFFFFFFFC gives 0).
  - RECOVER:
    - redirect=0 after its first cycle.
    - flush stays high while the counter is nonzero, decrementing each cycle. The stall input does not freeze this countdown.
    - At 0 → IDLE: flush=0, busy=0.
- Total flush duration = FLUSH_CYCLES cycles. FLUSH_CYCLES=1 returns to IDLE after the single redirect cycle.
- A correct prediction causes no output activity.
- Reset asserted mid-RECOVER: immediately clears flush, redirect and busy, and restores all counters.

Optional Feature:
- Macro BRANCH_PREDICT_STATS_EN.
- Defined: adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - stat_branches increments on each res.
  - stat_mispredicts increments on each mis.
  - Both wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/header (branch_predict.vh, next to branch.vh):
  - FSM state encodings ST_IDLE, ST_RECOVER.
  - Counter constants CNT_SNT=00, CNT_WNT=01, CNT_WT=10, CNT_ST=11.
  - Default BHT_INDEX_BITS.
- One natural sub-module, `sat_counter2`: 2-bit saturating up/down update logic. Instantiated per entry, or used as a function-equivalent block.

Test Plan:
1. Reset, then id_branch=1, id_pc=0x100 → id_pred_taken=0. All outputs 0.
2. Resolve ex_pc=0x100, taken, ex_pred_taken=0, ex_target=0x80.
   - Next cycle: redirect=1, redirect_pc=0x80, flush=1.
   - flush stays high exactly 2 cycles, then busy=0.
   - id_pc=0x100 then predicts 1 (counter 10).
3. Three taken resolves at 0x200 with ex_pred_taken matching → counter saturates at 11, no redirect.
   - Three not-taken resolves (first mispredicts, redirect_pc=0x204) → counter 00.
4. Branch at EX during RECOVER (ex_branch=1, mismatched prediction) → no training, no second redirect.
   - Same branch with stall=1 in IDLE → ignored.
5. Same-cycle lookup/update on index of 0x300 → id_pred_taken shows the old value; the new value is visible next cycle.
6. Mispredict not-taken at ex_pc=0xFFFFFFFC → redirect_pc=0x00000000.
   - reset_n pulsed low mid-flush → flush=0 immediately.
   - With BRANCH_PREDICT_STATS_EN defined: stat_mispredicts=0 after reset.
